// File: rtl/sdram_pattern_tester_if.sv
// sdram_pattern_tester_if
//
// Purpose: command/data bus between the pattern tester and the DDR SDRAM
// controller user port. The tester is the master: it issues write/read
// commands and receives read data. The controller is the slave.
//
// Signals:
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  controller accepts the command this cycle
//   cmd_write  master->slave  1 = write, 0 = read
//   cmd_addr   master->slave  word address (AddrWidth bits)
//   cmd_wdata  master->slave  write data, meaningful only when cmd_write=1
//   rd_valid   slave->master  one pulse per read, returned in issue order
//   rd_data    slave->master  returned read data
interface sdram_pattern_tester_if #(
  parameter int AddrWidth = 23
) ();
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [AddrWidth-1:0] cmd_addr;
  logic [31:0]          cmd_wdata;
  logic                 rd_valid;
  logic [31:0]          rd_data;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester
//
// Purpose: traffic generator and checker placed directly upstream of the
// DDR SDRAM controller. Once the controller reports initialisation complete,
// it writes the address-derived pattern P(a) = {a[15:0]^Seed, ~a[15:0]} to
// addresses 0..Words-1, reads the same range back with at most
// MaxOutstanding reads in flight, and compares every returned word.
//
// Ports:
//   i_clock       controller user clock
//   i_reset       asynchronous reset, active low
//   i_ctrl_ready  controller initialisation complete (level)
//   bus           command/read-data bus to the controller (master side)
//   o_busy        test in progress
//   o_done        test finished (sticky until reset)
//   o_fail        mismatch or protocol error seen (sticky until reset)
//   o_err_count   mismatch count, saturating at 255
//   o_leds        {done, fail, busy, state[1:0], wr_phase_done,
//                  err_count!=0, heartbeat}
module sdram_pattern_tester #(
  parameter int          AddrWidth      = 23,
  parameter int          Words          = 1024,
  parameter int          MaxOutstanding = 8,
  parameter logic [15:0] Seed           = 16'hA5C3
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_ctrl_ready,
  sdram_pattern_tester_if.master        bus,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_fail,
  output logic [7:0]                    o_err_count,
  output logic [7:0]                    o_leds
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_READ   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int                   ExpWidth   = AddrWidth + 1;
  localparam logic [AddrWidth-1:0] LastAddr   = AddrWidth'(Words - 1);
  localparam logic [ExpWidth-1:0]  WordsCount = ExpWidth'(Words);
  localparam logic [3:0]           MaxOut     = 4'(MaxOutstanding);

  state_t               r_state;
  logic                 r_cmdValid;
  logic                 r_cmdWrite;
  logic [AddrWidth-1:0] r_cmdAddr;
  logic [31:0]          r_cmdWdata;
  logic [ExpWidth-1:0]  r_expect;
  logic [3:0]           r_outstanding;
  logic                 r_issueDone;
  logic                 r_wrPhaseDone;
  logic                 r_errNonZero;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_fail;
  logic [7:0]           r_errCount;
  logic [23:0]          r_hbCount;
  logic                 r_heartbeat;

  logic                 w_cmdFire;
  logic                 w_readFire;
  logic                 w_rdAccepted;
  logic                 w_protoErr;
  logic                 w_mismatch;
  logic                 w_issueDoneNext;
  logic [3:0]           w_outstandingNext;
  logic [AddrWidth-1:0] w_addrInc;

  function automatic logic [31:0] pattern(input logic [15:0] a);
    return {a ^ Seed, ~a};
  endfunction

  // A return with nothing outstanding is a protocol error and is neither
  // counted against the outstanding reads nor compared against the pattern.
  assign w_cmdFire       = r_cmdValid & bus.cmd_ready;
  assign w_readFire      = w_cmdFire & (r_state == ST_READ);
  assign w_rdAccepted    = bus.rd_valid & (r_outstanding != 4'd0);
  assign w_protoErr      = bus.rd_valid & (r_outstanding == 4'd0);
  assign w_mismatch      = w_rdAccepted & (bus.rd_data != pattern(16'(r_expect)));
  assign w_issueDoneNext = r_issueDone | (w_readFire & (r_cmdAddr == LastAddr));
  assign w_addrInc       = r_cmdAddr + 1'b1;

  // Outstanding reads for the next cycle; a simultaneous issue and return
  // cancel out.
  always_comb begin
    w_outstandingNext = r_outstanding;
    if (w_readFire && !w_rdAccepted) begin
      w_outstandingNext = r_outstanding + 4'd1;
    end else if (!w_readFire && w_rdAccepted) begin
      w_outstandingNext = r_outstanding - 4'd1;
    end
  end

  // Main sequencer, read checker and heartbeat. cmd_valid for the read
  // phase is computed from the next outstanding count so the registered
  // output never offers a read that would exceed the in-flight limit, and a
  // stalled command can never be withdrawn (stalling can only lower the
  // count).
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_cmdValid    <= 1'b0;
      r_cmdWrite    <= 1'b0;
      r_cmdAddr     <= '0;
      r_cmdWdata    <= '0;
      r_expect      <= '0;
      r_outstanding <= '0;
      r_issueDone   <= 1'b0;
      r_wrPhaseDone <= 1'b0;
      r_errNonZero  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_fail        <= 1'b0;
      r_errCount    <= '0;
      r_hbCount     <= '0;
      r_heartbeat   <= 1'b0;
    end else begin
      r_hbCount <= r_hbCount + 24'd1;
      if (&r_hbCount) begin
        r_heartbeat <= ~r_heartbeat;
      end

      if (w_protoErr) begin
        r_fail <= 1'b1;
      end
      if (w_rdAccepted) begin
        r_expect <= r_expect + 1'b1;
        if (w_mismatch) begin
          r_fail       <= 1'b1;
          r_errNonZero <= 1'b1;
          if (r_errCount != 8'hFF) begin
            r_errCount <= r_errCount + 8'd1;
          end
        end
      end
      r_outstanding <= w_outstandingNext;

      case (r_state)
        ST_IDLE: begin
          if (i_ctrl_ready) begin
            r_state    <= ST_WRITE;
            r_busy     <= 1'b1;
            r_cmdValid <= 1'b1;
            r_cmdWrite <= 1'b1;
            r_cmdAddr  <= '0;
            r_cmdWdata <= pattern(16'd0);
          end
        end

        ST_WRITE: begin
          if (w_cmdFire) begin
            if (r_cmdAddr == LastAddr) begin
              r_state       <= ST_READ;
              r_wrPhaseDone <= 1'b1;
              r_cmdAddr     <= '0;
              r_cmdWrite    <= 1'b0;
              r_cmdWdata    <= '0;
              r_cmdValid    <= 1'b1;
            end else begin
              r_cmdAddr  <= w_addrInc;
              r_cmdWdata <= pattern(16'(w_addrInc));
            end
          end
        end

        ST_READ: begin
          if (w_readFire && (r_cmdAddr != LastAddr)) begin
            r_cmdAddr <= w_addrInc;
          end
          r_issueDone <= w_issueDoneNext;
          r_cmdValid  <= !w_issueDoneNext && (w_outstandingNext < MaxOut);
          if (r_issueDone && (r_outstanding == 4'd0) && (r_expect == WordsCount)) begin
            r_state <= ST_FINISH;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        ST_FINISH: begin
          r_cmdValid <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_valid = r_cmdValid;
  assign bus.cmd_write = r_cmdWrite;
  assign bus.cmd_addr  = r_cmdAddr;
  assign bus.cmd_wdata = r_cmdWdata;

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_fail      = r_fail;
  assign o_err_count = r_errCount;
  assign o_leds      = {r_done, r_fail, r_busy, r_state, r_wrPhaseDone, r_errNonZero, r_heartbeat};

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// tb_sdram_pattern_tester
//
// Purpose: scoreboard bench for sdram_pattern_tester with Words=16. Expected
// commands are queued when a run starts; a monitor pops and compares them on
// every command transfer while also acting as the controller's memory and
// scheduling read returns with a configurable latency.
module tb_sdram_pattern_tester;

  localparam int AddrW = 23;

  typedef struct {
    logic             wr;
    logic [AddrW-1:0] addr;
    logic [31:0]      data;
  } cmd_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       ctrlReady;
  logic       busy;
  logic       done;
  logic       fail;
  logic [7:0] errCount;
  logic [7:0] leds;

  int   errors = 0;
  int   checks = 0;
  int   cycleCount = 0;
  int   benchOutstanding = 0;
  int   maxOutSeen = 0;
  int   latency = 3;
  logic readyRandom = 1'b0;
  logic corruptEn = 1'b0;
  logic spuriousReq = 1'b0;

  cmd_t        expQ[$];
  rd_t         pendQ[$];
  logic [31:0] mem [16];

  // Hand-computed P(a) for a = 0..15 with Seed 0xA5C3.
  logic [31:0] wrTable [16] = '{
    32'hA5C3FFFF, 32'hA5C2FFFE, 32'hA5C1FFFD, 32'hA5C0FFFC,
    32'hA5C7FFFB, 32'hA5C6FFFA, 32'hA5C5FFF9, 32'hA5C4FFF8,
    32'hA5CBFFF7, 32'hA5CAFFF6, 32'hA5C9FFF5, 32'hA5C8FFF4,
    32'hA5CFFFF3, 32'hA5CEFFF2, 32'hA5CDFFF1, 32'hA5CCFFF0
  };

  sdram_pattern_tester_if #(.AddrWidth(AddrW)) bus ();

  sdram_pattern_tester #(
    .AddrWidth      (AddrW),
    .Words          (16),
    .MaxOutstanding (8),
    .Seed           (16'hA5C3)
  ) dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_ctrl_ready (ctrlReady),
    .bus          (bus),
    .o_busy       (busy),
    .o_done       (done),
    .o_fail       (fail),
    .o_err_count  (errCount),
    .o_leds       (leds)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #3;
  endtask

  // Controller model driver: acts 2 time units after each rising edge and
  // sets cmd_ready/rd_valid for the following edge.
  initial begin : driver
    bus.cmd_ready = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.rd_data   = '0;
    forever begin
      @(posedge clock);
      cycleCount++;
      #2;
      if (!reset) begin
        bus.rd_valid = 1'b0;
      end else begin
        bus.cmd_ready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
        if (spuriousReq) begin
          bus.rd_valid = 1'b1;
          bus.rd_data  = 32'hDEADBEEF;
          spuriousReq  = 1'b0;
        end else if (pendQ.size() > 0 && pendQ[0].due <= cycleCount + 1) begin
          bus.rd_valid = 1'b1;
          bus.rd_data  = pendQ[0].data;
          void'(pendQ.pop_front());
        end else begin
          bus.rd_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: at each falling edge the bus shows what the next rising edge
  // will transfer. Compares transfers against the expected queue, checks
  // that stalled commands hold still, and feeds the memory model.
  initial begin : monitor
    cmd_t        exp;
    logic        prevStall;
    logic [55:0] prevCmd;
    logic [31:0] data;
    int          a;
    prevStall = 1'b0;
    prevCmd   = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("stall_hold", {bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata},
                      {1'b1, prevCmd});
        end
        if (bus.rd_valid && benchOutstanding > 0) benchOutstanding--;
        if (bus.cmd_valid && bus.cmd_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("cmd_unexpected", {bus.cmd_write, bus.cmd_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            exp = expQ.pop_front();
            checkOutput("cmd", {bus.cmd_write, bus.cmd_addr, bus.cmd_write ? bus.cmd_wdata : 32'h0},
                        {exp.wr, exp.addr, exp.data});
          end
          a = int'(bus.cmd_addr[3:0]);
          if (bus.cmd_write) begin
            mem[a] = bus.cmd_wdata;
          end else begin
            data = mem[a];
            if (corruptEn && (a == 5 || a == 9)) data = data ^ 32'h1;
            pendQ.push_back('{cycleCount + 1 + latency, data});
            benchOutstanding++;
            if (benchOutstanding > maxOutSeen) maxOutSeen = benchOutstanding;
          end
        end
        prevStall = bus.cmd_valid && !bus.cmd_ready;
        prevCmd   = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
      end
    end
  end

  task automatic applyReset();
    reset     = 1'b0;
    ctrlReady = 1'b0;
    expQ.delete();
    pendQ.delete();
    benchOutstanding = 0;
    maxOutSeen       = 0;
    spuriousReq      = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic loadExpected();
    for (int i = 0; i < 16; i++) expQ.push_back('{1'b1, AddrW'(i), wrTable[i]});
    for (int i = 0; i < 16; i++) expQ.push_back('{1'b0, AddrW'(i), 32'h0});
  endtask

  task automatic applyStimulus(input string name, input logic rdyRand, input int lat,
                               input logic corrupt, input logic dropReady,
                               input logic expFail, input logic [7:0] expErr,
                               input logic [7:0] expLeds);
    int n;
    applyReset();
    readyRandom = rdyRand;
    latency     = lat;
    corruptEn   = corrupt;
    loadExpected();
    ctrlReady = 1'b1;
    n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
      if (dropReady && n == 10) ctrlReady = 1'b0;
    end
    checkOutput($sformatf("%s_done", name), done, 1);
    checkOutput($sformatf("%s_busy", name), busy, 0);
    checkOutput($sformatf("%s_fail", name), fail, expFail);
    checkOutput($sformatf("%s_errcount", name), errCount, expErr);
    checkOutput($sformatf("%s_leds", name), leds, expLeds);
    checkOutput($sformatf("%s_cmds_left", name), expQ.size(), 0);
    checkOutput($sformatf("%s_max_outstanding_ok", name), maxOutSeen <= 8, 1);
  endtask

  initial begin : mainSeq
    int n;
    reset     = 1'b0;
    ctrlReady = 1'b0;
    tick();
    tick();
    checkOutput("rst_cmd", {bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata}, 64'd0);
    checkOutput("rst_status", {busy, done, fail, errCount, leds}, 64'd0);
    reset = 1'b1;
    tick();
    tick();
    checkOutput("idle_waits", {bus.cmd_valid, busy}, 64'd0);

    applyStimulus("ideal", 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'd0, 8'h9C);
    applyStimulus("backpressure", 1'b1, 3, 1'b0, 1'b1, 1'b0, 8'd0, 8'h9C);
    applyStimulus("lat40", 1'b0, 40, 1'b0, 1'b0, 1'b0, 8'd0, 8'h9C);
    checkOutput("lat40_max_outstanding", maxOutSeen, 8);
    applyStimulus("corrupt", 1'b0, 3, 1'b1, 1'b0, 1'b1, 8'd2, 8'hDE);

    // Spurious read return while idle.
    applyReset();
    spuriousReq = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("spur_fail", fail, 1);
    checkOutput("spur_errcount", errCount, 0);
    checkOutput("spur_leds", leds, 8'h40);
    checkOutput("spur_idle", {bus.cmd_valid, busy, done}, 64'd0);

    // Reset in the middle of the read phase with reads in flight.
    applyReset();
    readyRandom = 1'b0;
    latency     = 40;
    corruptEn   = 1'b0;
    loadExpected();
    ctrlReady = 1'b1;
    n = 0;
    while (!(leds[4:3] == 2'b10 && benchOutstanding >= 4) && n < 500) begin
      tick();
      n++;
    end
    checkOutput("midrst_reached_read", (leds[4:3] == 2'b10 && benchOutstanding >= 4), 1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_cmd", {bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata}, 64'd0);
    checkOutput("midrst_status", {busy, done, fail, errCount, leds}, 64'd0);
    applyStimulus("rerun", 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'd0, 8'h9C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_pattern_tester.md
Name: sdram_pattern_tester

Overview:
- Traffic generator and checker that sits directly upstream of the DDR SDRAM controller in the BigSDRAM design, feeding its command/data port.
- After controller initialisation completes, writes a deterministic address-derived pattern over a configurable address range, then reads the range back and compares every word.
- Reports progress, pass/fail and error count on status outputs and an 8-bit LED vector for the board.

Parameters:
- AddrWidth, 23, word-address width of the controller port (2 bank + 13 row + 8 column bits).
- Words, 1024, number of consecutive words tested, starting at address 0; must be in 2..2^AddrWidth.
- MaxOutstanding, 8, maximum read commands issued whose data has not yet returned; must be in 1..15.
- Seed, 16'hA5C3, constant XORed into the pattern's upper half.

Ports:
- clock  in  1  single block clock (controller user clock, clock0 domain).
- reset  in  1  asynchronous, active-low reset.
- ctrl_ready  in  1  controller initialisation complete; level signal.
- cmd_valid  out  1  command present.
- cmd_ready  in  1  controller accepts the command this cycle.
- cmd_write  out  1  1 = write, 0 = read.
- cmd_addr  out  AddrWidth  word address.
- cmd_wdata  out  32  write data; meaningful only when cmd_write=1.
- rd_valid  in  1  read data returned; one pulse per read, in issue order.
- rd_data  in  32  returned data.
- busy  out  1  test in progress.
- done  out  1  test finished (sticky).
- fail  out  1  at least one mismatch or protocol error (sticky).
- err_count  out  8  mismatch count, saturating at 255.
- leds  out  8  {done, fail, busy, state[1:0], wr_phase_done, err_count!=0, heartbeat}.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; cmd_valid=0, cmd_write=0, cmd_addr=0, cmd_wdata=0; busy=0, done=0, fail=0, err_count=0, leds=0. All counters clear. The outstanding count is discarded, and rd_valid pulses from reads issued before reset are not counted after release.
- Pattern: P(a) = {a[15:0] ^ Seed, ~a[15:0]}. Address bits above bit 15 are ignored by the pattern.
- State encoding: IDLE=0, WRITE=1, READ=2, FINISH=3.
- Handshake: a command transfers on any cycle with cmd_valid && cmd_ready. While cmd_valid=1 and cmd_ready=0, cmd_write, cmd_addr and cmd_wdata stay stable. cmd_valid never drops without a transfer.
- IDLE:
  - When ctrl_ready is sampled 1, go to WRITE on the next edge and set busy=1.
  - cmd_valid=1 from the first WRITE cycle, with cmd_write=1, cmd_addr=0, cmd_wdata=P(0).
- WRITE:
  - On each transfer the address increments and cmd_wdata updates to P(addr) in the same cycle (registered), giving back-to-back writes at full rate when cmd_ready stays high.
  - The transfer of address Words-1 sets wr_phase_done and goes to READ, with the address reset to 0.
- READ:
  - cmd_valid=1, cmd_write=0, cmd_addr=issue address. cmd_valid is held 0 whenever outstanding==MaxOutstanding and no rd_valid occurs this cycle.
  - outstanding += accepted read, -= rd_valid. Simultaneous issue and return leave it unchanged.
  - After issuing address Words-1, cmd_valid=0 and no further commands are issued; remain in READ until outstanding==0.
- Checking (READ state):
  - A separate expect counter, starting at 0, increments on every rd_valid.
  - Mismatch when rd_data != P(expect): err_count increments (saturating at 255) and fail is set.
  - Once the expect counter reaches Words and outstanding==0, go to FINISH.
- Protocol error: rd_valid when outstanding==0 sets fail. err_count is not incremented.
- FINISH: busy=0, done=1. Terminal until reset; a ctrl_ready drop is ignored.
- ctrl_ready dropping during WRITE or READ: the block ignores it and continues.
- heartbeat toggles every 2^24 clocks; free-running after reset.
- All outputs are registered.

Test Plan:
- Ideal controller (cmd_ready=1, read data returned 3 cycles after each read, correct contents), Words=16 -> 16 consecutive writes with data 0x...; P(0)=0xA5C3FFFF, P(1)=0xA5C2FFFE. Then 16 reads; done=1, fail=0, err_count=0, leds[7]=1.
- Random cmd_ready backpressure (50%) -> cmd_addr and cmd_wdata are stable while stalled; the full write/read sequence is unchanged; pass.
- Read latency of 40 cycles with MaxOutstanding=8 -> never more than 8 reads unacknowledged; the 9th read waits for the first rd_valid; pass.
- Memory model corrupts addresses 5 and 9 (bit 0 flipped) -> err_count=2, fail=1, done=1.
- Spurious rd_valid in IDLE -> fail=1, err_count=0.
- Reset asserted mid-READ with reads outstanding -> all outputs return to reset values immediately. Restart on ctrl_ready; earlier in-flight data is not counted; pass on a clean rerun.
